// File: rtl/seg_display_mux_pkg.sv
// seg_display_mux_pkg: segment patterns and digit slot indices shared by the display mux and decoder
package seg_display_mux_pkg;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [1:0] DIG_SEC_LO = 2'd0;
  localparam logic [1:0] DIG_SEC_HI = 2'd1;
  localparam logic [1:0] DIG_MIN_LO = 2'd2;
  localparam logic [1:0] DIG_MIN_HI = 2'd3;
endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: BCD digit to active-low {g..a} segments, dash for anything above max_i
//   val_i : digit value
//   max_i : largest legal value for this digit position (5 or 9)
//   seg_o : active-low segments {g,f,e,d,c,b,a}
module seven_seg_decoder
  import seg_display_mux_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic [3:0] max_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_DASH;
    if (val_i <= max_i)
      case (val_i)
        4'd0: seg_o = SEG_0;
        4'd1: seg_o = SEG_1;
        4'd2: seg_o = SEG_2;
        4'd3: seg_o = SEG_3;
        4'd4: seg_o = SEG_4;
        4'd5: seg_o = SEG_5;
        4'd6: seg_o = SEG_6;
        4'd7: seg_o = SEG_7;
        4'd8: seg_o = SEG_8;
        4'd9: seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
  end
endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux: 4-digit common-anode MM:SS display multiplexer with field blink
//   clk, rst          : clock, synchronous active-high reset
//   min_high/min_low  : minutes tens (0-5) / units (0-9)
//   sec_high/sec_low  : seconds tens (0-5) / units (0-9)
//   adj, sel          : blink enable, field select (1 = minutes, 0 = seconds)
//   seg, dp, an       : active-low segments {g..a}, decimal point, digit anodes
module seg_display_mux
  import seg_display_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] min_high,
  input  logic [3:0] min_low,
  input  logic [2:0] sec_high,
  input  logic [3:0] sec_low,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0] idx_q, idx_d;
  logic blink_phase_q, blink_phase_d;
  logic [2:0] min_high_q, sec_high_q;
  logic [3:0] min_low_q, sec_low_q;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic dp_q, dp_d;
  logic refresh_wrap, blink_wrap, blank;
  logic [3:0] digit, digit_max;
  always_comb begin
    refresh_wrap  = refresh_cnt_q == RW'(REFRESH_DIV - 1);
    blink_wrap    = blink_cnt_q == BW'(BLINK_DIV - 1);
    refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
    idx_d         = refresh_wrap ? idx_q + 2'd1 : idx_q;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    digit = idx_q == DIG_SEC_LO ? sec_low_q :
            idx_q == DIG_SEC_HI ? {1'b0, sec_high_q} :
            idx_q == DIG_MIN_LO ? min_low_q : {1'b0, min_high_q};
    // odd slots hold tens digits, which only go up to 5
    digit_max = idx_q[0] ? 4'd5 : 4'd9;
    // idx[1] set means a minutes slot, so it matches sel directly
    blank = adj && blink_phase_q && (sel == idx_q[1]);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    dp_d  = !(idx_q == DIG_MIN_LO && !blank);
  end
  seven_seg_decoder u_dec (
    .val_i(digit),
    .max_i(digit_max),
    .seg_o(seg_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      min_high_q    <= '0;
      min_low_q     <= '0;
      sec_high_q    <= '0;
      sec_low_q     <= '0;
      seg_q         <= SEG_OFF;
      an_q          <= 4'b1111;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      // capture all digits at once at frame end so a frame never mixes two times
      if (refresh_wrap && idx_q == DIG_MIN_HI) begin
        min_high_q <= min_high;
        min_low_q  <= min_low;
        sec_high_q <= sec_high;
        sec_low_q  <= sec_low;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end
  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: randomized check of seg_display_mux against a frame/slot arithmetic model
module tb_seg_display_mux;
  localparam int R = 4;
  localparam int B = 16;
  localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] min_high = '0, sec_high = '0;
  logic [3:0] min_low = '0, sec_low = '0;
  logic adj = 1'b0, sel = 1'b0;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  int n_chk = 0, n_fail = 0;
  int k = 0;
  bit armed = 1'b0;
  int snap [4];
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic e_dp;
  seg_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .min_high(min_high), .min_low(min_low), .sec_high(sec_high), .sec_low(sec_low),
    .adj(adj), .sel(sel),
    .seg(seg), .dp(dp), .an(an)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask
  function automatic logic [6:0] ref_seg(int d, int mx);
    return d > mx ? 7'b0111111 : PAT[d];
  endfunction
  // k counts edges since reset release; slot, frame and blink phase follow from it by division
  initial forever begin
    int slot, ph;
    bit blank;
    @(posedge clk);
    if (rst) begin
      e_an = 4'hf; e_seg = 7'h7f; e_dp = 1'b1;
      k = 0; armed = 1'b1;
      foreach (snap[i]) snap[i] = 0;
    end else begin
      slot  = (k / R) % 4;
      ph    = (k / B) % 2;
      e_seg = ref_seg(snap[slot], (slot % 2) ? 5 : 9);
      blank = adj && ph == 1 && (sel == (slot >= 2));
      e_an  = blank ? 4'hf : ~(4'b0001 << slot);
      e_dp  = !(slot == 2 && !blank);
      if (k % (4 * R) == 4 * R - 1) begin
        snap[0] = int'(sec_low); snap[1] = int'(sec_high);
        snap[2] = int'(min_low); snap[3] = int'(min_high);
      end
      k++;
    end
    if (armed) begin
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
    end
  end
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_time(input int mh, input int ml, input int sh, input int sl);
    min_high = 3'(mh); min_low = 4'(ml); sec_high = 3'(sh); sec_low = 4'(sl);
  endtask
  task automatic wait_slot(input int s, input int r);
    int found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if ((k / R) % 4 == s && k % R == r) found = 1;
      else @(negedge clk);
    end
    check("wait_slot", 32'(found), 32'd1);
  endtask
  initial begin
    set_time(5, 9, 5, 9);
    run(3);
    rst = 1'b0;
    run(4 * R * 2 + 3);
    set_time(1, 2, 3, 4);
    run(4 * R * 2);
    wait_slot(1, 1);
    sec_low = 4'd5;
    run(4 * R * 2);
    adj = 1'b1; sel = 1'b1;
    run(4 * B);
    sel = 1'b0;
    run(4 * B);
    adj = 1'b0;
    min_low = 4'd12; sec_high = 3'd7;
    run(4 * R * 2);
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        set_time(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) == 0) adj = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) sel = 1'($urandom_range(0, 1));
    end
    adj = 1'b0;
    set_time(4, 7, 2, 8);
    wait_slot(2, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(4 * R * 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
